// File: rtl/echo_delay_ctrl.sv
// echo_delay_ctrl
//   Echo/delay-line controller for the karaoke voice path. Each accepted mic
//   sample is mixed with the sample written `delay` samples earlier, scaled by
//   `gain`. The saturated mix goes to the output and is also written back into
//   the sample RAM, so the echo keeps feeding back.
//
//   The controller drives a dual-port RAM with a registered, rden-gated read
//   (1-cycle latency). Every sample takes four clocks, one per state:
//   IDLE (accept) -> RD (read) -> MIX (mix) -> OUT (output + write-back).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   input sample handshake
//   delay                       echo delay in samples (0 = full buffer depth)
//   gain                        feedback gain, unsigned Q0.GAIN_WIDTH
//   out_valid/out_data          one-cycle strobe with the mixed sample
//   ram_wren/ram_wraddress/ram_data   RAM write port
//   ram_rden/ram_rdaddress/ram_q      RAM read port (q valid one cycle after rden)
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic        [ADDR_WIDTH-1:0] delay,
  input  logic        [GAIN_WIDTH-1:0] gain,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         ram_wren,
  output logic        [ADDR_WIDTH-1:0] ram_wraddress,
  output logic signed [DATA_WIDTH-1:0] ram_data,
  output logic                         ram_rden,
  output logic        [ADDR_WIDTH-1:0] ram_rdaddress,
  input  logic signed [DATA_WIDTH-1:0] ram_q
);

  localparam int FILL_W = ADDR_WIDTH + 1;
  localparam logic [FILL_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RD, MIX, OUT} state_t;

  state_t                         state, state_nxt;
  logic        [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic        [FILL_W-1:0]       fill, fill_nxt;
  logic signed [DATA_WIDTH-1:0]   smp_p0, smp_p0_nxt;
  logic        [ADDR_WIDTH-1:0]   dly_p0, dly_p0_nxt;
  logic        [GAIN_WIDTH-1:0]   gn_p0, gn_p0_nxt;
  logic                           in_ready_nxt, out_valid_nxt, ram_wren_nxt, ram_rden_nxt;
  logic signed [DATA_WIDTH-1:0]   out_data_nxt, ram_data_nxt;
  logic        [ADDR_WIDTH-1:0]   ram_wraddress_nxt, ram_rdaddress_nxt;
  logic        [FILL_W-1:0]       eff_delay;
  logic signed [DATA_WIDTH-1:0]   mix_sum;

  // Clamp a DATA_WIDTH+1 bit sum back into the DATA_WIDTH signed range.
  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      saturate = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      saturate = s[DATA_WIDTH-1:0];
  endfunction

  // echo = (q * gain) >>> GAIN_WIDTH (floor); masked to 0 while the delay line
  // has not yet been filled, so stale RAM contents never reach the output.
  function automatic logic signed [DATA_WIDTH-1:0] mix(input logic signed [DATA_WIDTH-1:0] q,
                                                       input logic        [GAIN_WIDTH-1:0] g,
                                                       input logic signed [DATA_WIDTH-1:0] x,
                                                       input logic                         mask);
    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_WIDTH:0]   echo;
    prod = q * $signed({1'b0, g});
    echo = (DATA_WIDTH+1)'(prod >>> GAIN_WIDTH);
    if (mask)
      echo = '0;
    mix = saturate(echo + {x[DATA_WIDTH-1], x});
  endfunction

  assign eff_delay = (dly_p0 == '0) ? DEPTH : {1'b0, dly_p0};
  assign mix_sum   = mix(ram_q, gn_p0, smp_p0, fill < eff_delay);

  always_comb begin
    state_nxt         = state;
    wr_ptr_nxt        = wr_ptr;
    fill_nxt          = fill;
    smp_p0_nxt        = smp_p0;
    dly_p0_nxt        = dly_p0;
    gn_p0_nxt         = gn_p0;
    in_ready_nxt      = in_ready;
    out_valid_nxt     = 1'b0;
    out_data_nxt      = out_data;
    ram_wren_nxt      = 1'b0;
    ram_wraddress_nxt = ram_wraddress;
    ram_data_nxt      = ram_data;
    ram_rden_nxt      = 1'b0;
    ram_rdaddress_nxt = ram_rdaddress;
    case (state)
      IDLE: begin
        // in_ready is registered: it comes up one edge after reset release.
        in_ready_nxt = 1'b1;
        if (in_ready && in_valid) begin
          smp_p0_nxt        = in_data;
          dly_p0_nxt        = delay;
          gn_p0_nxt         = gain;
          in_ready_nxt      = 1'b0;
          ram_rden_nxt      = 1'b1;
          ram_rdaddress_nxt = wr_ptr - delay;
          state_nxt         = RD;
        end
      end
      RD: state_nxt = MIX;
      MIX: begin
        out_valid_nxt     = 1'b1;
        out_data_nxt      = mix_sum;
        ram_wren_nxt      = 1'b1;
        ram_wraddress_nxt = wr_ptr;
        ram_data_nxt      = mix_sum;
        state_nxt         = OUT;
      end
      OUT: begin
        wr_ptr_nxt   = wr_ptr + 1'b1;
        fill_nxt     = (fill == DEPTH) ? fill : fill + 1'b1;
        in_ready_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      fill          <= '0;
      smp_p0        <= '0;
      dly_p0        <= '0;
      gn_p0         <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      ram_wren      <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      ram_rden      <= 1'b0;
      ram_rdaddress <= '0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      fill          <= fill_nxt;
      smp_p0        <= smp_p0_nxt;
      dly_p0        <= dly_p0_nxt;
      gn_p0         <= gn_p0_nxt;
      in_ready      <= in_ready_nxt;
      out_valid     <= out_valid_nxt;
      out_data      <= out_data_nxt;
      ram_wren      <= ram_wren_nxt;
      ram_wraddress <= ram_wraddress_nxt;
      ram_data      <= ram_data_nxt;
      ram_rden      <= ram_rden_nxt;
      ram_rdaddress <= ram_rdaddress_nxt;
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
module tb_echo_delay_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic        [10:0] delay = '0;
  logic        [7:0]  gain = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               ram_wren;
  logic        [10:0] ram_wraddress;
  logic signed [15:0] ram_data;
  logic               ram_rden;
  logic        [10:0] ram_rdaddress;
  logic signed [15:0] ram_q = '0;

  logic signed [15:0] mem [0:2047];

  int checks = 0;
  int fails = 0;

  echo_delay_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(11), .GAIN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .delay(delay), .gain(gain),
    .out_valid(out_valid), .out_data(out_data),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_data(ram_data),
    .ram_rden(ram_rden), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Dual-port RAM with registered, rden-gated read.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdaddress];
  end

  // Junk content stands in for uninitialised RAM.
  task automatic junk_ram();
    for (int i = 0; i < 2048; i++) mem[i] = 16'sd12345;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Send one sample; returns the strobed output and write-port values.
  // delay/gain are scrambled right after acceptance to exercise latching.
  task automatic send(input logic signed [15:0] d, input logic [10:0] dl, input logic [7:0] g,
                      output logic signed [15:0] o, output logic [10:0] wa,
                      output logic signed [15:0] wd, output logic we, output bit ok);
    int n;
    ok = 1'b0; o = '0; wa = '0; wd = '0; we = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1; in_data = d; delay = dl; gain = g;
    @(posedge clk); #1;
    in_valid = 1'b0; delay = dl + 11'd3; gain = ~g; in_data = 16'sd7777;
    n = 0;
    while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
    if (out_valid) begin
      ok = 1'b1; o = out_data; wa = ram_wraddress; wd = ram_data; we = ram_wren;
    end else begin
      checks++; fails++;
      $display("FAIL send_timeout: no out_valid for input %0d", d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b od=%0d we=%b rd=%b, required all 0",
               in_ready, out_valid, out_data, ram_wren, ram_rden);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b required 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b required 1", in_ready); end
  endtask

  task automatic test_impulse();
    logic signed [15:0] o, wd; logic [10:0] wa; logic we; bit ok;
    int exp_o [15] = '{1000,0,0,0,500,0,0,0,250,0,0,0,125,0,0};
    junk_ram();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      send((i == 0) ? 16'sd1000 : 16'sd0, 11'd4, 8'd128, o, wa, wd, we, ok);
      if (ok) begin
        checks++;
        if (o !== 16'(exp_o[i]) || wd !== 16'(exp_o[i]) || wa !== 11'(i) || we !== 1'b1) begin
          fails++;
          $display("FAIL impulse[%0d]: got out=%0d wdata=%0d waddr=%0d wren=%b, required out=wdata=%0d waddr=%0d wren=1",
                   i, o, wd, wa, we, exp_o[i], i);
        end
      end
    end
  endtask

  task automatic test_warmup();
    logic signed [15:0] o, wd; logic [10:0] wa; logic we; bit ok;
    junk_ram();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      send((i <= 8) ? 16'(i) : 16'sd0, 11'd8, 8'd255, o, wa, wd, we, ok);
      if (ok) begin
        checks++;
        if (o !== ((i <= 8) ? 16'(i) : (i == 9) ? 16'sd0 : 16'sd1)) begin
          fails++;
          $display("FAIL warmup[%0d]: got %0d required %0d", i, o, (i <= 8) ? i : (i == 9) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] o, wd; logic [10:0] wa; logic we; bit ok;
    for (int s = 0; s < 2; s++) begin
      logic signed [15:0] x, lim;
      x   = (s == 0) ? 16'sd30000 : -16'sd30000;
      lim = (s == 0) ? 16'sd32767 : -16'sd32768;
      do_reset();
      send(x, 11'd1, 8'd255, o, wa, wd, we, ok);
      if (ok) begin
        checks++;
        if (o !== x) begin fails++; $display("FAIL sat_first[%0d]: got %0d required %0d", s, o, x); end
      end
      send(x, 11'd1, 8'd255, o, wa, wd, we, ok);
      if (ok) begin
        checks++;
        if (o !== lim || wd !== lim) begin
          fails++; $display("FAIL sat_clip[%0d]: got out=%0d wdata=%0d required %0d", s, o, wd, lim);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic signed [15:0] o, wd; logic [10:0] wa; logic we; bit ok;
    int nonzero;
    junk_ram();
    do_reset();
    nonzero = 0;
    send(16'sd2000, 11'd0, 8'd128, o, wa, wd, we, ok);
    if (ok) begin
      checks++;
      if (o !== 16'sd2000) begin fails++; $display("FAIL wrap_first: got %0d required 2000", o); end
    end
    for (int i = 1; i < 2048; i++) begin
      send(16'sd0, 11'd0, 8'd128, o, wa, wd, we, ok);
      if (ok && o !== 16'sd0) nonzero++;
    end
    checks++;
    if (nonzero != 0) begin fails++; $display("FAIL wrap_zeros: got %0d nonzero outputs required 0", nonzero); end
    send(16'sd0, 11'd0, 8'd128, o, wa, wd, we, ok);
    if (ok) begin
      checks++;
      if (o !== 16'sd1000 || wa !== 11'd0 || wd !== 16'sd1000) begin
        fails++; $display("FAIL wrap_echo: got out=%0d waddr=%0d wdata=%0d required 1000 @0", o, wa, wd);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc [0:47];
    int first, accepts, overlap, bad_ov, bad_rdy;
    do_reset();
    first = -1; accepts = 0; overlap = 0; bad_ov = 0; bad_rdy = 0;
    delay = 11'd1; gain = 8'd0; in_data = 16'sd5; in_valid = 1'b1;
    for (int k = 0; k < 48; k++) begin
      acc[k] = in_ready && in_valid;
      if (acc[k]) accepts++;
      if (acc[k] && first < 0) first = k;
      if (first >= 0 && (in_ready !== (((k - first) % 4) == 0))) bad_rdy++;
      if (ram_rden && ram_wren) overlap++;
      if (k >= 3 && out_valid !== acc[k-3]) bad_ov++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (accepts != 12) begin fails++; $display("FAIL b2b_accepts: got %0d required 12", accepts); end
    checks++;
    if (bad_rdy != 0) begin fails++; $display("FAIL b2b_ready_spacing: got %0d off-cycle ready samples required 0", bad_rdy); end
    checks++;
    if (bad_ov != 0) begin fails++; $display("FAIL b2b_out_latency: got %0d misaligned out_valid samples required 0", bad_ov); end
    checks++;
    if (overlap != 0) begin fails++; $display("FAIL b2b_rden_wren: got %0d overlaps required 0", overlap); end
  endtask

  task automatic test_reset_midop();
    logic signed [15:0] o, wd; logic [10:0] wa; logic we; bit ok;
    int wr_seen;
    do_reset();
    in_valid = 1'b1; in_data = 16'sd1234; delay = 11'd1; gain = 8'd255;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ram_rden !== 1'b1) begin fails++; $display("FAIL midop_in_rd: got rden=%b required 1", ram_rden); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, ram_wren, ram_wraddress, ram_data, ram_rden, ram_rdaddress} !== '0) begin
      fails++; $display("FAIL midop_async_clear: got rdy=%b ov=%b we=%b rd=%b required all 0",
                        in_ready, out_valid, ram_wren, ram_rden);
    end
    wr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (ram_wren) wr_seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ram_wren) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin fails++; $display("FAIL midop_no_write: got %0d wren cycles required 0", wr_seen); end
    send(16'sd500, 11'd1, 8'd255, o, wa, wd, we, ok);
    if (ok) begin
      checks++;
      if (o !== 16'sd500) begin fails++; $display("FAIL midop_first: got %0d required 500", o); end
    end
    send(16'sd0, 11'd1, 8'd255, o, wa, wd, we, ok);
    if (ok) begin
      checks++;
      if (o !== 16'sd498) begin fails++; $display("FAIL midop_echo: got %0d required 498", o); end
    end
    checks++;
    if (out_data !== 16'sd498) begin fails++; $display("FAIL hold_out_data: got %0d required 498", out_data); end
  endtask

  initial begin
    junk_ram();
    test_reset();
    test_impulse();
    test_warmup();
    test_saturation();
    test_wrap();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
